// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_reg
//  Description : ID/EX pipeline register. It captures the WB/MEM/EX control
//                groups from the ID-stage bubble mux. It also captures the
//                register operands, the immediate, PC+4 and the register
//                addresses, and presents them to EX one cycle later.
//                Supports stall (hold), flush (squash to bubble), a valid tag
//                and a saturating count of bubbles loaded since reset.
//  Ports       : clk_i / rst_i (async, active-low)
//                stall_i, flush_i, bubble_i    - pipeline control
//                WB_i, MEM_i, EX_i             - control groups from bubble mux
//                pc_i, rs_data_i, rt_data_i,
//                imm_i                         - data fields (DATA_W)
//                rs_addr_i, rt_addr_i,
//                rd_addr_i                     - register addresses (5 bits)
//                *_o                           - registered copies of the above
//                valid_o                       - EX slot holds a real instruction
//                bubble_cnt_o                  - saturating bubble count (CNT_W)
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              bubble_i,
    input  logic [1:0]        WB_i,
    input  logic [1:0]        MEM_i,
    input  logic [3:0]        EX_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [4:0]        rs_addr_i,
    input  logic [4:0]        rt_addr_i,
    input  logic [4:0]        rd_addr_i,
    output logic [1:0]        WB_o,
    output logic [1:0]        MEM_o,
    output logic [3:0]        EX_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [4:0]        rs_addr_o,
    output logic [4:0]        rt_addr_o,
    output logic [4:0]        rd_addr_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [1:0]        wb_q,       wb_d;
    logic [1:0]        mem_q,      mem_d;
    logic [3:0]        ex_q,       ex_d;
    logic [DATA_W-1:0] pc_q,       pc_d;
    logic [DATA_W-1:0] rs_data_q,  rs_data_d;
    logic [DATA_W-1:0] rt_data_q,  rt_data_d;
    logic [DATA_W-1:0] imm_q,      imm_d;
    logic [4:0]        rs_addr_q,  rs_addr_d;
    logic [4:0]        rt_addr_q,  rt_addr_d;
    logic [4:0]        rd_addr_q,  rd_addr_d;
    logic              valid_q,    valid_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic              bubble_load;

    always_comb begin
        // Default is hold, which is exactly the stall behaviour.
        wb_d        = wb_q;
        mem_d       = mem_q;
        ex_d        = ex_q;
        pc_d        = pc_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        rd_addr_d   = rd_addr_q;
        valid_d     = valid_q;
        bubble_load = 1'b0;

        if (flush_i) begin
            // Flush beats stall and absorbs a coincident hazard bubble, so
            // the counter advances at most once per edge.
            wb_d        = '0;
            mem_d       = '0;
            ex_d        = '0;
            pc_d        = '0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            imm_d       = '0;
            rs_addr_d   = '0;
            rt_addr_d   = '0;
            rd_addr_d   = '0;
            valid_d     = 1'b0;
            bubble_load = 1'b1;
        end else if (!stall_i) begin
            // Hazard bubbles arrive with control already zeroed by the mux;
            // data fields pass through untouched.
            wb_d        = WB_i;
            mem_d       = MEM_i;
            ex_d        = EX_i;
            pc_d        = pc_i;
            rs_data_d   = rs_data_i;
            rt_data_d   = rt_data_i;
            imm_d       = imm_i;
            rs_addr_d   = rs_addr_i;
            rt_addr_d   = rt_addr_i;
            rd_addr_d   = rd_addr_i;
            valid_d     = ~bubble_i;
            bubble_load = bubble_i;
        end

        // Saturating counter: stops at all-ones, never wraps.
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_load && (bubble_cnt_q != c_CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_q         <= '0;
            mem_q        <= '0;
            ex_q         <= '0;
            pc_q         <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            rd_addr_q    <= '0;
            valid_q      <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            wb_q         <= wb_d;
            mem_q        <= mem_d;
            ex_q         <= ex_d;
            pc_q         <= pc_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            rs_addr_q    <= rs_addr_d;
            rt_addr_q    <= rt_addr_d;
            rd_addr_q    <= rd_addr_d;
            valid_q      <= valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign WB_o         = wb_q;
    assign MEM_o        = mem_q;
    assign EX_o         = ex_q;
    assign pc_o         = pc_q;
    assign rs_data_o    = rs_data_q;
    assign rt_data_o    = rt_data_q;
    assign imm_o        = imm_q;
    assign rs_addr_o    = rs_addr_q;
    assign rt_addr_o    = rt_addr_q;
    assign rd_addr_o    = rd_addr_q;
    assign valid_o      = valid_q;
    assign bubble_cnt_o = bubble_cnt_q;

endmodule
`default_nettype wire

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage CPU.
- Sits directly downstream of the ID-stage control bubble mux. It captures that mux's WB/MEM/EX control groups together with register operands, the immediate and the register addresses, and presents them to the EX stage one cycle later.
- Supports stall (hold), flush (squash to bubble), a valid tag, and a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 32, width of operand, immediate and PC fields
- CNT_W, 16, width of bubble counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-low
- stall_i  in  1  hold all stage contents this cycle
- flush_i  in  1  load a bubble this cycle; overrides stall_i
- bubble_i  in  1  high when the bubble mux is selecting zeros (hazard select)
- WB_i  in  2  WB control group from bubble mux
- MEM_i  in  2  MEM control group from bubble mux
- EX_i  in  4  EX control group from bubble mux (ALUSrc, ALUOp[1:0], RegDst)
- pc_i  in  DATA_W  PC+4 of ID instruction
- rs_data_i  in  DATA_W  register file read data 1
- rt_data_i  in  DATA_W  register file read data 2
- imm_i  in  DATA_W  sign-extended immediate
- rs_addr_i  in  5  source register 1 address
- rt_addr_i  in  5  source register 2 address
- rd_addr_i  in  5  destination register address
- WB_o  out  2  registered WB control
- MEM_o  out  2  registered MEM control
- EX_o  out  4  registered EX control
- pc_o, rs_data_o, rt_data_o, imm_o  out  DATA_W  registered data fields
- rs_addr_o, rt_addr_o, rd_addr_o  out  5  registered address fields
- valid_o  out  1  EX-stage slot holds a real instruction
- bubble_cnt_o  out  CNT_W  number of bubbles loaded since reset, saturating

Behaviour:
- Reset: asynchronous, active-low. While rst_i=0, every output is 0, including valid_o and bubble_cnt_o. Release takes effect at the next rising edge. Reset asserted mid-operation clears everything immediately, regardless of stall_i or flush_i.
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Per-edge priority, highest first:
  1. flush_i=1 → load bubble.
  2. stall_i=1 → hold every output, including valid_o and bubble_cnt_o.
  3. Otherwise → load inputs.
- Load bubble:
  - WB_o, MEM_o, EX_o = 0.
  - Data and address fields = 0.
  - valid_o = 0.
  - bubble_cnt_o increments.
- Load inputs:
  - All fields = inputs.
  - valid_o = ~bubble_i.
  - If bubble_i=1, bubble_cnt_o increments. Control fields are taken as presented (the mux already zeroes them); data fields are loaded unmodified.
- flush_i and stall_i both high: flush wins, bubble loaded, counter increments once.
- flush_i and bubble_i both high: single bubble, counter increments once.
- bubble_cnt_o saturates at 2^CNT_W-1 and never wraps. Once saturated, further bubbles leave it unchanged.
- No combinational path from any input to any output.
- Control outputs must never be nonzero while valid_o=0 after a flush-loaded bubble.

Test Plan:
- Reset: drive rst_i=0 mid-stream with nonzero outputs → all outputs 0 asynchronously, before the next edge. Release, then load WB_i=2'b11, MEM_i=2'b01, EX_i=4'b1010, rs_data_i=32'h1234_5678 → next cycle outputs match exactly, valid_o=1, bubble_cnt_o=0.
- Stall: load pc_i=32'h0000_0040. Then hold stall_i=1 for 3 cycles while inputs change to pc_i=32'h0000_0044 → pc_o stays 32'h0000_0040 for all 3 cycles. Release → pc_o=32'h0000_0044 one cycle later.
- Hazard bubble: bubble_i=1 with WB_i=MEM_i=EX_i=0, rt_addr_i=5'd9 → WB_o=MEM_o=EX_o=0, valid_o=0, rt_addr_o=9, bubble_cnt_o 0→1.
- Flush over stall: load valid instruction WB_i=2'b10. Then assert flush_i=1 and stall_i=1 together → all fields 0, valid_o=0, bubble_cnt_o increments by exactly 1. With flush_i=1 and bubble_i=1 together → counter +1 only.
- Saturation: CNT_W=4, issue 20 consecutive bubbles → bubble_cnt_o reaches 15 and stays 15. A subsequent valid load keeps it at 15.
- Back-to-back: 4 distinct instructions on consecutive cycles with no stall or flush → outputs track inputs with exactly 1-cycle delay, valid_o=1 throughout.
